// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: datapath I/O bus and device-side handshake signals of
// io_port_ctrl, bundled as one interface.
//   master modport: datapath/device side (drives strobes, address, store data,
//                   inta, device receive word and transmit ack)
//   slave  modport: io_port_ctrl side (drives read data, intr, dev_in_ready,
//                   transmit word and valid)
interface io_port_ctrl_if;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        intr;
  logic        inta;
  logic [31:0] dev_in_data;
  logic        dev_in_valid;
  logic        dev_in_ready;
  logic [31:0] dev_out_data;
  logic        dev_out_valid;
  logic        dev_out_ack;

  modport master (
    output io_cs, io_rd, io_wr, io_addr, io_wdata, inta,
           dev_in_data, dev_in_valid, dev_out_ack,
    input  io_rdata, intr, dev_in_ready, dev_out_data, dev_out_valid
  );

  modport slave (
    input  io_cs, io_rd, io_wr, io_addr, io_wdata, inta,
           dev_in_data, dev_in_valid, dev_out_ack,
    output io_rdata, intr, dev_in_ready, dev_out_data, dev_out_valid
  );
endinterface

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O port controller on the datapath I/O bus.
// Receive FIFO for device words, transmit holding register with valid/ack
// handshake, optional interrupt request.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - io_port_ctrl_if.slave: io_cs/io_rd/io_wr/io_addr/io_wdata/io_rdata,
//            intr/inta, dev_in_data/valid/ready, dev_out_data/valid/ack
// Register map (io_addr[3:2]): 0 DATA_IN, 1 DATA_OUT, 2 STATUS, 3 CONTROL.
// Build option: define IO_PORT_IRQ_EN to build the interrupt FSM; otherwise
// intr is tied 0, inta is ignored and the ie bit does not exist.
module io_port_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input logic         clk,
  input logic         reset,
  io_port_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {OUT_IDLE, OUT_BUSY} out_state_t;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          ovr_q, ovr_d;
  out_state_t    out_state_q, out_state_d;

  logic [1:0]  sel;
  logic        wr_en, rd_en, empty, full, push, pop, flush, wr_out, wr_ctrl;
  logic        ie, intr_w;
  logic [31:0] status;

  assign sel     = bus.io_addr[3:2];
  assign wr_en   = bus.io_cs & bus.io_wr;
  // A simultaneous read strobe is dropped so io_rdata holds during a write.
  assign rd_en   = bus.io_cs & bus.io_rd & ~bus.io_wr;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = bus.dev_in_valid & ~full;
  assign pop     = rd_en & (sel == 2'd0) & ~empty;
  assign wr_out  = wr_en & (sel == 2'd1);
  assign wr_ctrl = wr_en & (sel == 2'd3);
  assign flush   = wr_ctrl & bus.io_wdata[1];

`ifdef IO_PORT_IRQ_EN
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACKED} irq_state_t;
  irq_state_t irq_state_q, irq_state_d;
  logic       ie_q, ie_d;

  always_comb begin
    ie_d = ie_q;
    if (wr_ctrl) ie_d = bus.io_wdata[0];
  end

  always_comb begin
    irq_state_d = irq_state_q;
    case (irq_state_q)
      IRQ_IDLE:  if (ie_q && !empty) irq_state_d = IRQ_REQ;
      IRQ_REQ: begin
        if (empty || !ie_q)  irq_state_d = IRQ_IDLE;
        else if (bus.inta)   irq_state_d = IRQ_ACKED;
      end
      IRQ_ACKED: if (empty) irq_state_d = IRQ_IDLE;
      default:   irq_state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_state_q <= IRQ_IDLE;
      ie_q        <= 1'b0;
    end else begin
      irq_state_q <= irq_state_d;
      ie_q        <= ie_d;
    end
  end

  assign ie     = ie_q;
  assign intr_w = (irq_state_q == IRQ_REQ);

  logic unused_bits;
  assign unused_bits = ^{bus.io_addr[31:4], bus.io_addr[1:0]};
`else
  assign ie     = 1'b0;
  assign intr_w = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.io_addr[31:4], bus.io_addr[1:0], bus.inta};
`endif

  always_comb begin
    status       = '0;
    status[0]    = empty;
    status[1]    = full;
    status[2]    = (out_state_q == OUT_BUSY);
    status[3]    = ovr_q;
    status[4]    = ie;
    status[5]    = intr_w;
    status[8 +: CW] = count_q;
  end

  // Receive FIFO pointers/count; flush overrides any same-cycle push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (sel)
        2'd0:    rdata_d = empty ? '0 : mem_q[rd_ptr_q];
        2'd1:    rdata_d = out_data_q;
        2'd2:    rdata_d = status;
        default: rdata_d = {31'b0, ie};
      endcase
    end
  end

  // Transmit FSM; a write while busy only flags overflow, even if acked.
  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    ovr_d       = ovr_q;
    if (wr_ctrl && bus.io_wdata[2]) ovr_d = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (wr_out) begin
          out_data_d  = bus.io_wdata;
          out_state_d = OUT_BUSY;
        end
      end
      OUT_BUSY: begin
        if (wr_out)          ovr_d       = 1'b1;
        if (bus.dev_out_ack) out_state_d = OUT_IDLE;
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.dev_in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      out_data_q  <= '0;
      ovr_q       <= 1'b0;
      out_state_q <= OUT_IDLE;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      out_data_q  <= out_data_d;
      ovr_q       <= ovr_d;
      out_state_q <= out_state_d;
    end
  end

  assign bus.io_rdata      = rdata_q;
  assign bus.intr          = intr_w;
  assign bus.dev_in_ready  = ~full;
  assign bus.dev_out_data  = out_data_q;
  assign bus.dev_out_valid = (out_state_q == OUT_BUSY);
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl (FIFO_DEPTH = 4).
module tb_io_port_ctrl;
`ifdef IO_PORT_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  io_port_ctrl_if bus ();

  io_port_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.io_cs = 1'b1; bus.io_rd = 1'b1; bus.io_wr = 1'b0; bus.io_addr = a;
    tick();
    d = bus.io_rdata;
    bus.io_cs = 1'b0; bus.io_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.io_cs = 1'b1; bus.io_wr = 1'b1; bus.io_rd = 1'b0;
    bus.io_addr = a; bus.io_wdata = v;
    tick();
    bus.io_cs = 1'b0; bus.io_wr = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    bus.dev_in_valid = 1'b1; bus.dev_in_data = v;
    tick();
    bus.dev_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) tick();
    n_checks++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", bus.io_rdata, 32'h0); end
    n_checks++; if (bus.dev_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.dev_out_valid); end
    reset = 1'b0;
    rd(32'h8, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
    n_checks++; if (bus.dev_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.dev_in_ready); end
    n_checks++; if (bus.intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b expected 0", bus.intr); end
  endtask

  task automatic test_fifo_fill;
    logic [31:0] d;
    for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + 32'(i));
    n_checks++; if (bus.dev_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", bus.dev_in_ready); end
    rd(32'h8, d);
    n_checks++; if (d !== 32'h402) begin n_fail++; $display("FAIL fill_status: got %h expected %h", d, 32'h402); end
    for (int i = 1; i <= 4; i++) begin
      rd(32'h0, d);
      n_checks++; if (d !== 32'hA5A5_0000 + 32'(i)) begin n_fail++; $display("FAIL fill_pop%0d: got %h expected %h", i, d, 32'hA5A5_0000 + 32'(i)); end
    end
    rd(32'h8, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL fill_empty_status: got %h expected %h", d, 32'h1); end
    rd(32'h0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_full_pop;
    logic [31:0] d;
    for (int i = 1; i <= 4; i++) push(32'hB000_0000 + 32'(i));
    // full: valid asserted with a pop in the same cycle must not push
    bus.dev_in_valid = 1'b1; bus.dev_in_data = 32'hB000_0005;
    rd(32'h0, d);
    n_checks++; if (d !== 32'hB000_0001) begin n_fail++; $display("FAIL fullpop_data: got %h expected %h", d, 32'hB000_0001); end
    n_checks++; if (bus.dev_in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready: got %b expected 1", bus.dev_in_ready); end
    rd(32'h8, d);  // valid still high: this cycle pushes
    bus.dev_in_valid = 1'b0;
    n_checks++; if (d !== 32'h300) begin n_fail++; $display("FAIL fullpop_count3: got %h expected %h", d, 32'h300); end
    rd(32'h8, d);
    n_checks++; if (d !== 32'h402) begin n_fail++; $display("FAIL fullpop_count4: got %h expected %h", d, 32'h402); end
    for (int i = 2; i <= 5; i++) begin
      rd(32'h0, d);
      n_checks++; if (d !== 32'hB000_0000 + 32'(i)) begin n_fail++; $display("FAIL wrap_pop%0d: got %h expected %h", i, d, 32'hB000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_transmit;
    logic [31:0] d;
    wr(32'h4, 32'h1234_5678);
    n_checks++; if (bus.dev_out_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid: got %b expected 1", bus.dev_out_valid); end
    wr(32'h4, 32'hDEAD_BEEF);
    n_checks++; if (bus.dev_out_data !== 32'h1234_5678) begin n_fail++; $display("FAIL tx_data_kept: got %h expected %h", bus.dev_out_data, 32'h1234_5678); end
    rd(32'h8, d);
    n_checks++; if (d !== 32'hD) begin n_fail++; $display("FAIL tx_status_busy_ovr: got %h expected %h", d, 32'hD); end
    rd(32'h4, d);
    n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL tx_readback: got %h expected %h", d, 32'h1234_5678); end
    bus.dev_out_ack = 1'b1; tick(); bus.dev_out_ack = 1'b0;
    n_checks++; if (bus.dev_out_valid !== 1'b0) begin n_fail++; $display("FAIL tx_ack_drop: got %b expected 0", bus.dev_out_valid); end
    bus.dev_out_ack = 1'b1; tick(); bus.dev_out_ack = 1'b0;  // ack while idle
    rd(32'h8, d);
    n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL tx_status_ovr: got %h expected %h", d, 32'h9); end
    wr(32'hC, 32'h4);
    rd(32'h8, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL tx_ovr_clear: got %h expected %h", d, 32'h1); end
    // write and ack in the same busy cycle
    wr(32'h4, 32'hAAAA_0001);
    bus.dev_out_ack = 1'b1;
    wr(32'h4, 32'hBBBB_0002);
    bus.dev_out_ack = 1'b0;
    n_checks++; if (bus.dev_out_valid !== 1'b0) begin n_fail++; $display("FAIL tx_wrack_valid: got %b expected 0", bus.dev_out_valid); end
    n_checks++; if (bus.dev_out_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL tx_wrack_data: got %h expected %h", bus.dev_out_data, 32'hAAAA_0001); end
    rd(32'h8, d);
    n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL tx_wrack_ovr: got %h expected %h", d, 32'h9); end
    wr(32'hC, 32'h4);
  endtask

  task automatic test_strobe_priority;
    logic [31:0] d;
    rd(32'h8, d);
    bus.io_cs = 1'b1; bus.io_rd = 1'b1; bus.io_wr = 1'b1;
    bus.io_addr = 32'h4; bus.io_wdata = 32'h0000_CAFE;
    tick();
    bus.io_cs = 1'b0; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
    n_checks++; if (bus.io_rdata !== 32'h1) begin n_fail++; $display("FAIL rdwr_hold: got %h expected %h", bus.io_rdata, 32'h1); end
    n_checks++; if (bus.dev_out_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL rdwr_write: got %h expected %h", bus.dev_out_data, 32'h0000_CAFE); end
    bus.dev_out_ack = 1'b1; tick(); bus.dev_out_ack = 1'b0;
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr(32'hC, 32'h1);
    rd(32'hC, d);
    n_checks++; if (d !== {31'b0, IRQ}) begin n_fail++; $display("FAIL irq_ie_read: got %h expected %h", d, {31'b0, IRQ}); end
    push(32'h11);
    rd(32'h8, d);
    n_checks++; if (d !== (IRQ ? 32'h110 : 32'h100)) begin n_fail++; $display("FAIL irq_status1: got %h expected %h", d, IRQ ? 32'h110 : 32'h100); end
    n_checks++; if (bus.intr !== IRQ) begin n_fail++; $display("FAIL irq_raise: got %b expected %b", bus.intr, IRQ); end
    bus.inta = 1'b1; tick(); bus.inta = 1'b0;
    n_checks++; if (bus.intr !== 1'b0) begin n_fail++; $display("FAIL irq_ack_drop: got %b expected 0", bus.intr); end
    push(32'h22);
    tick();
    n_checks++; if (bus.intr !== 1'b0) begin n_fail++; $display("FAIL irq_acked_quiet: got %b expected 0", bus.intr); end
    rd(32'h8, d);
    n_checks++; if (d !== (IRQ ? 32'h210 : 32'h200)) begin n_fail++; $display("FAIL irq_status2: got %h expected %h", d, IRQ ? 32'h210 : 32'h200); end
    rd(32'h0, d);
    n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL irq_pop1: got %h expected %h", d, 32'h11); end
    rd(32'h0, d);
    n_checks++; if (d !== 32'h22) begin n_fail++; $display("FAIL irq_pop2: got %h expected %h", d, 32'h22); end
    push(32'h33);
    tick();
    n_checks++; if (bus.intr !== IRQ) begin n_fail++; $display("FAIL irq_reraise: got %b expected %b", bus.intr, IRQ); end
    wr(32'hC, 32'h0);
    rd(32'h0, d);
    n_checks++; if (bus.intr !== 1'b0) begin n_fail++; $display("FAIL irq_ie_clear: got %b expected 0", bus.intr); end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    push(32'h71);
    push(32'h72);
    bus.dev_in_valid = 1'b1; bus.dev_in_data = 32'h73;
    wr(32'hC, 32'h2);
    bus.dev_in_valid = 1'b0;
    rd(32'h8, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL flush_status: got %h expected %h", d, 32'h1); end
    rd(32'h0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL flush_read: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_abort;
    wr(32'h4, 32'h5555_AAAA);
    push(32'h99);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.dev_out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", bus.dev_out_valid); end
    n_checks++; if (bus.dev_out_data !== 32'h0) begin n_fail++; $display("FAIL abort_data: got %h expected %h", bus.dev_out_data, 32'h0); end
    tick();
    reset = 1'b0;
    begin
      logic [31:0] d;
      rd(32'h8, d);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL abort_status: got %h expected %h", d, 32'h1); end
    end
  endtask

  initial begin
    bus.io_cs = 1'b0; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
    bus.io_addr = '0; bus.io_wdata = '0; bus.inta = 1'b0;
    bus.dev_in_data = '0; bus.dev_in_valid = 1'b0; bus.dev_out_ack = 1'b0;
    test_reset();
    test_fifo_fill();
    test_full_pop();
    test_transmit();
    test_strobe_priority();
    test_irq();
    test_flush();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
